// File: rtl/rs_issue_sched_pkg.sv
// rs_issue_sched_pkg
//   Shared helpers for the reservation-station issue scheduler.
//   No ports; imported by rs_issue_sched and psel_gen.
package rs_issue_sched_pkg;

  // Width of an occupancy down-counter that must hold lat-1.
  // Never narrower than one bit, so a fully pipelined FU still has a
  // legal (always-zero) counter.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/psel_gen.sv
// psel_gen
//   Multi-grant priority selector. Slot k of gnt_bus holds a one-hot
//   vector for the k-th lowest set bit of req (bit 0 has top priority),
//   or zero when req has fewer than k+1 set bits.
// Ports:
//   req     - request vector
//   gnt_bus - REQS one-hot-or-zero grant slots, ordered by priority
module psel_gen
  import rs_issue_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned REQS  = 2
) (
  input  logic [WIDTH-1:0]            req,
  output logic [REQS-1:0][WIDTH-1:0]  gnt_bus
);

  logic [WIDTH-1:0] remaining;
  logic             found;

  // Each slot takes the lowest request not claimed by an earlier slot.
  always_comb begin
    gnt_bus   = '0;
    remaining = req;
    found     = 1'b0;
    for (int unsigned k = 0; k < REQS; k++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (remaining[i] && !found) begin
          gnt_bus[k][i] = 1'b1;
          remaining[i]  = 1'b0;
          found         = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_issue_sched.sv
// rs_issue_sched
//   Issue scheduler for one FU class. Picks ready RS entries in
//   round-robin order starting at prio_ptr and hands the k-th picked
//   entry to the k-th available FU. Grants are combinational so the RS
//   can clear granted entries in the same cycle.
// Ports:
//   clock, reset      - rising-edge clock, async active-high reset
//   flush             - squash: no grants this cycle, state cleared next edge
//   inst_req          - entries ready to issue
//   fu_stall          - per-FU back-pressure
//   fu_issued_insts   - per-FU one-hot-or-zero granted entry
//   fu_issue_valid    - per-FU grant strobe
//   all_issued_insts  - OR of all FU grants
//   num_issued        - number of grants this cycle
//   fu_busy           - per-FU occupancy from an earlier multi-cycle grant
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NUM_FU = 2,
  parameter int unsigned FU_LAT = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [DEPTH-1:0]                 inst_req,
  input  logic [NUM_FU-1:0]                fu_stall,
  output logic [NUM_FU-1:0][DEPTH-1:0]     fu_issued_insts,
  output logic [NUM_FU-1:0]                fu_issue_valid,
  output logic [DEPTH-1:0]                 all_issued_insts,
  output logic [$clog2(NUM_FU+1)-1:0]      num_issued,
  output logic [NUM_FU-1:0]                fu_busy
);

  localparam int unsigned   PW        = $clog2(DEPTH);
  localparam int unsigned   BW        = cnt_width(FU_LAT);
  localparam int unsigned   NW        = $clog2(NUM_FU + 1);
  localparam logic [BW-1:0] BUSY_LOAD = BW'(FU_LAT - 1);

  logic [PW-1:0]                  prio_ptr;
  logic [PW-1:0]                  prio_ptr_nxt;
  logic [NUM_FU-1:0][BW-1:0]      busy_cnt;

  logic [DEPTH-1:0]               req_rot;
  logic [NUM_FU-1:0][DEPTH-1:0]   slot_rot;
  logic [NUM_FU-1:0][DEPTH-1:0]   slot_orig;
  logic [NUM_FU-1:0]              fu_avail;
  logic [NUM_FU-1:0]              fu_busy_int;
  logic [NUM_FU:0]                dummy_unused_guard;
  logic [NW-1:0]                  avail_seen;
  logic [DEPTH-1:0]               used_rot;
  logic [PW-1:0]                  last_rot;
  logic                           any_grant;

  assign dummy_unused_guard = '0;

  // Rotate right by prio_ptr: bit 0 of req_rot is entry prio_ptr, so
  // the fixed-priority selector scans circularly from the pointer.
  always_comb begin
    req_rot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      req_rot[i] = inst_req[PW'(i) + prio_ptr];
    end
  end

  psel_gen #(
    .WIDTH (DEPTH),
    .REQS  (NUM_FU)
  ) u_psel (
    .req     (req_rot),
    .gnt_bus (slot_rot)
  );

  // Rotate every slot back left into entry-index space.
  always_comb begin
    slot_orig = '0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_orig[k][PW'(i) + prio_ptr] = slot_rot[k][i];
      end
    end
  end

  always_comb begin
    fu_busy_int = '0;
    fu_avail    = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fu_busy_int[f] = (busy_cnt[f] != '0);
      fu_avail[f]    = !fu_busy_int[f] && !fu_stall[f] && !flush && !reset;
    end
  end

  assign fu_busy = fu_busy_int;

  // The n-th available FU (ascending index) takes selector slot n; FUs
  // past the number of picked entries see an all-zero slot.
  always_comb begin
    fu_issued_insts = '0;
    used_rot        = '0;
    avail_seen      = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (fu_avail[f]) begin
        for (int unsigned k = 0; k < NUM_FU; k++) begin
          if (NW'(k) == avail_seen) begin
            fu_issued_insts[f] = slot_orig[k];
            used_rot           = used_rot | slot_rot[k];
          end
        end
        avail_seen = avail_seen + NW'(1);
      end
    end
  end

  always_comb begin
    fu_issue_valid   = '0;
    all_issued_insts = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fu_issue_valid[f] = |fu_issued_insts[f];
      all_issued_insts  = all_issued_insts | fu_issued_insts[f];
    end
    num_issued = NW'($countones(all_issued_insts));
  end

  // Grants are a prefix of scan order, so the last granted entry is the
  // highest granted bit in rotated space; the next scan starts just past it.
  always_comb begin
    last_rot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (used_rot[i]) begin
        last_rot = PW'(i);
      end
    end
    any_grant    = |used_rot;
    prio_ptr_nxt = prio_ptr + last_rot + PW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_ptr <= '0;
      busy_cnt <= '0;
    end else if (flush) begin
      prio_ptr <= '0;
      busy_cnt <= '0;
    end else begin
      if (any_grant) begin
        prio_ptr <= prio_ptr_nxt;
      end
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        if (fu_issue_valid[f]) begin
          busy_cnt[f] <= BUSY_LOAD;
        end else if (busy_cnt[f] != '0) begin
          busy_cnt[f] <= busy_cnt[f] - BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_issue_sched.sv
module tb_rs_issue_sched;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush;
  logic [7:0] inst_req;
  logic [2:0] stall;

  always #5 clock = ~clock;

  // a: DEPTH=8 NUM_FU=2 FU_LAT=3
  logic [1:0][7:0] a_gnt;
  logic [1:0]      a_valid;
  logic [7:0]      a_all;
  logic [1:0]      a_num;
  logic [1:0]      a_busy;
  // b: DEPTH=8 NUM_FU=3 FU_LAT=2
  logic [2:0][7:0] b_gnt;
  logic [2:0]      b_valid;
  logic [7:0]      b_all;
  logic [1:0]      b_num;
  logic [2:0]      b_busy;
  // c: DEPTH=8 NUM_FU=1 FU_LAT=1
  logic [0:0][7:0] c_gnt;
  logic [0:0]      c_valid;
  logic [7:0]      c_all;
  logic [0:0]      c_num;
  logic [0:0]      c_busy;

  rs_issue_sched #(.DEPTH(8), .NUM_FU(2), .FU_LAT(3)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .inst_req(inst_req),
    .fu_stall(stall[1:0]), .fu_issued_insts(a_gnt), .fu_issue_valid(a_valid),
    .all_issued_insts(a_all), .num_issued(a_num), .fu_busy(a_busy)
  );

  rs_issue_sched #(.DEPTH(8), .NUM_FU(3), .FU_LAT(2)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .inst_req(inst_req),
    .fu_stall(stall), .fu_issued_insts(b_gnt), .fu_issue_valid(b_valid),
    .all_issued_insts(b_all), .num_issued(b_num), .fu_busy(b_busy)
  );

  rs_issue_sched #(.DEPTH(8), .NUM_FU(1), .FU_LAT(1)) dut_c (
    .clock(clock), .reset(reset), .flush(flush), .inst_req(inst_req),
    .fu_stall(stall[0:0]), .fu_issued_insts(c_gnt), .fu_issue_valid(c_valid),
    .all_issued_insts(c_all), .num_issued(c_num), .fu_busy(c_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: per configuration, a pointer and a list of
  // remaining-occupancy cycles per FU.
  int nfu_of [3] = '{2, 3, 1};
  int lat_of [3] = '{3, 2, 1};
  int m_ptr  [3];
  int m_busy [3][3];
  int e_gnt  [3][3];
  int e_n    [3];
  int e_last [3];
  int wait_c [3][8];
  int max_wait [3];
  logic cur_fl, cur_rst;

  task automatic model_eval(input int m, input logic [7:0] req, input logic [2:0] st,
                            input logic fl, input logic rst);
    int reqs[$];
    int fus[$];
    logic [2:0] e3;
    if (rst) begin
      m_ptr[m] = 0;
      for (int f = 0; f < 3; f++) m_busy[m][f] = 0;
    end
    for (int j = 0; j < 8; j++) begin
      e3 = 3'((m_ptr[m] + j) % 8);
      if (req[e3]) reqs.push_back(int'(e3));
    end
    for (int f = 0; f < nfu_of[m]; f++) begin
      if (!rst && !fl && (((st >> f) & 3'b001) == 3'b000) && m_busy[m][f] == 0)
        fus.push_back(f);
    end
    e_n[m] = 0;
    e_last[m] = -1;
    for (int f = 0; f < 3; f++) e_gnt[m][f] = -1;
    for (int k = 0; k < reqs.size() && k < fus.size(); k++) begin
      e_gnt[m][fus[k]] = reqs[k];
      e_n[m]++;
      e_last[m] = reqs[k];
    end
  endtask

  task automatic model_commit(input int m);
    if (cur_rst || cur_fl) begin
      m_ptr[m] = 0;
      for (int f = 0; f < 3; f++) m_busy[m][f] = 0;
    end else begin
      for (int f = 0; f < 3; f++) begin
        if (e_gnt[m][f] >= 0) m_busy[m][f] = lat_of[m] - 1;
        else if (m_busy[m][f] > 0) m_busy[m][f]--;
      end
      if (e_n[m] > 0) m_ptr[m] = (e_last[m] + 1) % 8;
    end
  endtask

  task automatic compare(input int m);
    logic [2:0][7:0] g;
    logic [2:0] v, bz, eb;
    logic [7:0] al, eal, eg;
    logic [1:0] n, f2;
    logic [2:0] e3;
    string p;
    case (m)
      0: begin p = "a"; g = {8'h00, a_gnt}; v = {1'b0, a_valid}; al = a_all; n = a_num; bz = {1'b0, a_busy}; end
      1: begin p = "b"; g = b_gnt; v = b_valid; al = b_all; n = b_num; bz = b_busy; end
      default: begin p = "c"; g = {16'h0000, c_gnt}; v = {2'b00, c_valid}; al = c_all; n = {1'b0, c_num}; bz = {2'b00, c_busy}; end
    endcase
    eal = '0;
    eb  = '0;
    for (int f = 0; f < nfu_of[m]; f++) begin
      f2 = 2'(f);
      eg = (e_gnt[m][f] >= 0) ? (8'h01 << e_gnt[m][f]) : 8'h00;
      eal = eal | eg;
      eb[f2] = (m_busy[m][f] != 0);
      check($sformatf("%s.gnt%0d", p, f), 32'(g[f2]), 32'(eg));
      check($sformatf("%s.valid%0d", p, f), 32'(v[f2]), 32'(eg != 8'h00));
    end
    check($sformatf("%s.all", p), 32'(al), 32'(eal));
    check($sformatf("%s.num", p), 32'(n), 32'(e_n[m]));
    check($sformatf("%s.busy", p), 32'(bz), 32'(eb));
    // Fairness bookkeeping from observed grants.
    for (int e = 0; e < 8; e++) begin
      e3 = 3'(e);
      if (cur_rst || cur_fl || !inst_req[e3] || al[e3]) begin
        wait_c[m][e] = 0;
      end else if (n != 2'd0) begin
        wait_c[m][e]++;
        if (wait_c[m][e] > max_wait[m]) max_wait[m] = wait_c[m][e];
      end
    end
  endtask

  task automatic cyc_begin(input logic [7:0] req, input logic [2:0] st,
                           input logic fl, input logic rst);
    inst_req = req;
    stall    = st;
    flush    = fl;
    reset    = rst;
    cur_fl   = fl;
    cur_rst  = rst;
    @(negedge clock);
    for (int m = 0; m < 3; m++) begin
      model_eval(m, req, st, fl, rst);
      compare(m);
    end
  endtask

  task automatic cyc_end();
    for (int m = 0; m < 3; m++) model_commit(m);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      cyc_begin(8'h00, 3'b000, 1'b0, 1'b0);
      cyc_end();
    end
  endtask

  logic [7:0] sticky, rnd_a, rnd_b, rq;
  logic [2:0] st_r;

  initial begin
    reset = 1'b1; flush = 1'b0; inst_req = '0; stall = '0;
    #1;
    // Requests pending during reset must not be granted.
    cyc_begin(8'hFF, 3'b000, 1'b0, 1'b1);
    check("a.rst_num", 32'(a_num), 32'd0);
    check("a.rst_all", 32'(a_all), 32'd0);
    cyc_end();
    cyc_begin(8'hFF, 3'b000, 1'b0, 1'b1); cyc_end();

    // First grant after reset: entries 0 and 7, pointer wraps to 0.
    cyc_begin(8'h81, 3'b000, 1'b0, 1'b0);
    check("a.wrap_fu0", 32'(a_gnt[0]), 32'h01);
    check("a.wrap_fu1", 32'(a_gnt[1]), 32'h80);
    check("a.wrap_num", 32'(a_num), 32'd2);
    cyc_end();
    idle(2);

    // Occupancy of FU0 for two cycles while FU1 keeps granting.
    cyc_begin(8'h01, 3'b000, 1'b0, 1'b0);
    check("a.occ_t0", 32'(a_gnt[0]), 32'h01);
    cyc_end();
    cyc_begin(8'h06, 3'b000, 1'b0, 1'b0);
    check("a.occ_t1_busy", 32'(a_busy), 32'h1);
    check("a.occ_t1_fu1", 32'(a_gnt[1]), 32'h02);
    cyc_end();
    cyc_begin(8'h04, 3'b000, 1'b0, 1'b0);
    check("a.occ_t2_busy", 32'(a_busy), 32'h3);
    check("a.occ_t2_num", 32'(a_num), 32'd0);
    cyc_end();
    cyc_begin(8'h04, 3'b000, 1'b0, 1'b0);
    check("a.occ_t3_fu0", 32'(a_gnt[0]), 32'h04);
    cyc_end();
    idle(3);

    // Drive pointer to 6, then wrap through 6,7.
    cyc_begin(8'h20, 3'b000, 1'b0, 1'b0); cyc_end();
    idle(2);
    cyc_begin(8'hC3, 3'b000, 1'b0, 1'b0);
    check("a.p6_fu0", 32'(a_gnt[0]), 32'h40);
    check("a.p6_fu1", 32'(a_gnt[1]), 32'h80);
    cyc_end();
    cyc_begin(8'hC3, 3'b000, 1'b0, 1'b0);
    check("a.p6_busy_num", 32'(a_num), 32'd0);
    cyc_end();
    idle(2);

    // FU0 stalled: FU1 takes the first entry.
    cyc_begin(8'h0F, 3'b001, 1'b0, 1'b0);
    check("a.stall_fu0", 32'(a_gnt[0]), 32'h00);
    check("a.stall_fu1", 32'(a_gnt[1]), 32'h01);
    check("a.stall_num", 32'(a_num), 32'd1);
    cyc_end();
    cyc_begin(8'h00, 3'b000, 1'b0, 1'b0);
    check("a.stall_busy", 32'(a_busy), 32'h2);
    cyc_end();

    // Flush while FU1 busy.
    cyc_begin(8'hFF, 3'b000, 1'b1, 1'b0);
    check("a.flush_num", 32'(a_num), 32'd0);
    check("a.flush_busy", 32'(a_busy), 32'h2);
    cyc_end();
    cyc_begin(8'h01, 3'b000, 1'b0, 1'b0);
    check("a.post_flush_busy", 32'(a_busy), 32'h0);
    check("a.post_flush_fu0", 32'(a_gnt[0]), 32'h01);
    cyc_end();

    // Reset abandons occupancy.
    cyc_begin(8'hFF, 3'b000, 1'b0, 1'b1);
    check("a.rst_busy", 32'(a_busy), 32'h0);
    cyc_end();
    cyc_begin(8'h03, 3'b000, 1'b0, 1'b0);
    check("a.post_rst_num", 32'(a_num), 32'd2);
    cyc_end();

    // Randomized traffic.
    for (int m = 0; m < 3; m++) begin
      max_wait[m] = 0;
      for (int e = 0; e < 8; e++) wait_c[m][e] = 0;
    end
    sticky = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ((cyc % 64) == 0) sticky = 8'($urandom);
      rnd_a = 8'($urandom);
      rnd_b = 8'($urandom);
      case ($urandom_range(0, 3))
        0: rq = rnd_a;
        1: rq = sticky | (rnd_a & rnd_b);
        2: rq = sticky;
        default: rq = rnd_a | rnd_b;
      endcase
      for (int f = 0; f < 3; f++) st_r[2'(f)] = ($urandom_range(0, 3) == 0);
      cyc_begin(rq, st_r, ($urandom_range(0, 49) == 0), ($urandom_range(0, 999) == 0));
      cyc_end();
    end
    for (int m = 0; m < 3; m++)
      check($sformatf("m%0d.starve", m), 32'(max_wait[m] < 8), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_issue_sched.md
RS_ISSUE_SCHED -- requirements
Module: rs_issue_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of RS entries; power of two, at least 2.
REQ-002 SHALL have parameter NUM_FU, default 2: FUs served; 1 <= NUM_FU <= DEPTH.
REQ-003 SHALL have parameter FU_LAT, default 1: cycles an FU stays occupied per grant; 1 = fully pipelined.
REQ-004 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1: squash; suppresses grants and reinitialises state.
REQ-007 SHALL have port inst_req, input, DEPTH: entries ready to issue to this FU class.
REQ-008 SHALL have port fu_stall, input, NUM_FU: FU f cannot accept this cycle.
REQ-009 SHALL have port fu_issued_insts, output, NUM_FU x DEPTH: one-hot or zero entry granted to each FU.
REQ-010 SHALL have port fu_issue_valid, output, NUM_FU: FU f received a grant this cycle.
REQ-011 SHALL have port all_issued_insts, output, DEPTH: OR of all FU grants.
REQ-012 SHALL have port num_issued, output, $clog2(NUM_FU+1): popcount of all_issued_insts.
REQ-013 SHALL have port fu_busy, output, NUM_FU: FU f occupied by an earlier multi-cycle grant.

Function
REQ-014 Grant outputs SHALL be combinational from inputs and current state (zero-cycle latency), so the RS clears granted entries in the same cycle.
REQ-015 FU f SHALL be available iff busy_cnt[f]==0, fu_stall[f]==0 and flush==0.
REQ-016 Requesting entries SHALL be scanned circularly from prio_ptr upward, wrapping DEPTH-1 to 0.
REQ-017 The k-th requesting entry in scan order SHALL go to the k-th available FU in ascending index; extra entries or FUs stay ungranted.
REQ-018 No entry SHALL be granted to more than one FU; no FU SHALL receive more than one entry.
REQ-019 num_issued SHALL equal min(popcount(inst_req), number of available FUs).
REQ-020 On a grant to FU f with FU_LAT>1, busy_cnt[f] SHALL load FU_LAT-1; a nonzero busy_cnt SHALL decrement by 1 each cycle; fu_busy[f] = (busy_cnt[f]!=0).
REQ-021 When num_issued>0, prio_ptr SHALL load (scan-order last granted index + 1) mod DEPTH; otherwise it holds.
REQ-022 flush=1 SHALL force all grant outputs and num_issued to 0 that cycle; next edge clears prio_ptr and all busy_cnt.
REQ-023 fu_stall SHALL not modify busy_cnt; a stalled busy FU keeps counting down.
REQ-024 inst_req all-zero SHALL give zero grants and leave state unchanged except busy countdown.
REQ-025 busy_cnt width SHALL be max(1,$clog2(FU_LAT)); prio_ptr width $clog2(DEPTH), wrapping naturally.

Reset
REQ-026 reset SHALL asynchronously clear prio_ptr to 0 and all busy_cnt to 0.
REQ-027 While reset is high, all grant outputs and num_issued SHALL be 0, fu_busy 0.
REQ-028 Reset asserted during a multi-cycle occupancy SHALL abandon it; first cycle after release all FUs are available.

Structure
REQ-029 No new package typedefs; parameters are module-local.
REQ-030 Selection SHALL instantiate psel_gen (WIDTH=DEPTH, REQS=NUM_FU) on inst_req rotated right by prio_ptr, rotating gnt_bus back left; FU ordering is local logic.
REQ-031 State SHALL be limited to prio_ptr and NUM_FU busy counters.

Verification (DEPTH=8, NUM_FU=2, FU_LAT=3 unless stated)
REQ-032 Reset, inst_req=8'b1000_0001, no stall -> FU0 gets entry 0, FU1 gets entry 7, num_issued=2, prio_ptr becomes 0 (7+1 wraps).
REQ-033 prio_ptr=6, inst_req=8'b1100_0011 -> FU0=entry 6, FU1=entry 7, prio_ptr becomes 0; next cycle same req while both busy -> no grants.
REQ-034 Grant FU0 at cycle t -> fu_busy[0]=1 at t+1,t+2, FU0 grantable again at t+3; FU1 still grants meanwhile.
REQ-035 fu_stall=2'b01, inst_req=8'h0F -> only FU1 granted entry 0, num_issued=1, busy_cnt[0] unchanged.
REQ-036 flush with inst_req=8'hFF and FU1 busy -> zero grants that cycle; next cycle prio_ptr=0, fu_busy=0.
REQ-037 Random inst_req/fu_stall, 10k cycles, NUM_FU in {1,3} -> REQ-018/019 invariants hold; every continuously requesting entry granted within DEPTH grant cycles.
